// File: rtl/prga.sv
// prga - RC4 pseudo-random generation stage.
//
// Uses the S-box that ksa leaves in S memory. Reads a length-prefixed
// ciphertext from CT and writes the length-prefixed plaintext to PT:
//   PT[0] = L, and for k = 1..L:
//   i += 1; j += S[i]; swap S[i], S[j]; PT[k] = S[S[i] + S[j]] ^ CT[k]
// Start is an en/rdy handshake; en is only sampled while rdy = 1.
// All S/CT/PT memories have a synchronous read with 1-cycle latency.
//
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   en / rdy              start request / idle-and-ready
//   s_addr, s_rddata, s_wrdata, s_wren   S-box memory port
//   ct_addr, ct_rddata                   ciphertext memory (read only)
//   pt_addr, pt_wrdata, pt_wren          plaintext memory (write only)
//
// Optional feature, macro PRGA_KS_TAP_EN:
//   adds ks_valid / ks_byte. These expose the keystream byte (pad) during
//   each plaintext byte write. They are 0 at all other times.
//
// Every output is a flop. Its D input is decoded from the next state and
// the next register values. As a result, no output has a combinational
// path from *_rddata, and each state drives its outputs for exactly the
// cycle it is resident.
module prga (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] ct_addr,
  input  logic [7:0] ct_rddata,
  output logic [7:0] pt_addr,
  output logic [7:0] pt_wrdata,
  output logic       pt_wren
`ifdef PRGA_KS_TAP_EN
  ,
  output logic       ks_valid,
  output logic [7:0] ks_byte
`endif
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    READ_LEN  = 4'd1,
    WAIT_LEN  = 4'd2,
    WRITE_LEN = 4'd3,
    READ_I    = 4'd4,
    WAIT_I    = 4'd5,
    READ_J    = 4'd6,
    WAIT_J    = 4'd7,
    WRITE_I   = 4'd8,
    WRITE_J   = 4'd9,
    READ_PAD  = 4'd10,
    WAIT_PAD  = 4'd11,
    WRITE_PT  = 4'd12
  } state_t;

  state_t     state_r, state_s;
  logic [7:0] i_r, j_r, k_r, len_r, si_r, sj_r, pad_r, ct_byte_r;
  logic [7:0] i_s, j_s, k_s, len_s, si_s, sj_s, pad_s, ct_byte_s;

  logic       rdy_s, s_wren_s, pt_wren_s;
  logic [7:0] s_addr_s, s_wrdata_s, ct_addr_s, pt_addr_s, pt_wrdata_s;
`ifdef PRGA_KS_TAP_EN
  logic       ks_valid_s;
  logic [7:0] ks_byte_s;
`endif

  // Next-state and datapath register update.
  always_comb begin
    state_s   = state_r;
    i_s       = i_r;
    j_s       = j_r;
    k_s       = k_r;
    len_s     = len_r;
    si_s      = si_r;
    sj_s      = sj_r;
    pad_s     = pad_r;
    ct_byte_s = ct_byte_r;
    case (state_r)
      IDLE: begin
        if (en) begin
          state_s = READ_LEN;
          i_s     = 8'd0;
          j_s     = 8'd0;
          k_s     = 8'd0;
        end else begin
          state_s = IDLE;
        end
      end
      READ_LEN: state_s = WAIT_LEN;
      WAIT_LEN: begin
        len_s   = ct_rddata;
        state_s = WRITE_LEN;
      end
      WRITE_LEN: begin
        if (len_r == 8'd0) begin
          state_s = IDLE;
        end else begin
          i_s     = 8'd1;
          k_s     = 8'd1;
          state_s = READ_I;
        end
      end
      READ_I: state_s = WAIT_I;
      WAIT_I: begin
        si_s    = s_rddata;
        j_s     = j_r + s_rddata;
        state_s = READ_J;
      end
      READ_J: state_s = WAIT_J;
      WAIT_J: begin
        sj_s    = s_rddata;
        state_s = WRITE_I;
      end
      WRITE_I:  state_s = WRITE_J;
      WRITE_J:  state_s = READ_PAD;
      READ_PAD: state_s = WAIT_PAD;
      WAIT_PAD: begin
        pad_s     = s_rddata;
        ct_byte_s = ct_rddata;
        state_s   = WRITE_PT;
      end
      WRITE_PT: begin
        // The end test comes before the increment, so k never passes 255.
        if (k_r == len_r) begin
          state_s = IDLE;
        end else begin
          i_s     = i_r + 8'd1;
          k_s     = k_r + 8'd1;
          state_s = READ_I;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Output decode from the upcoming state. The outputs are registered next to it.
  always_comb begin
    rdy_s       = 1'b0;
    s_addr_s    = 8'd0;
    s_wrdata_s  = 8'd0;
    s_wren_s    = 1'b0;
    ct_addr_s   = 8'd0;
    pt_addr_s   = 8'd0;
    pt_wrdata_s = 8'd0;
    pt_wren_s   = 1'b0;
`ifdef PRGA_KS_TAP_EN
    ks_valid_s  = 1'b0;
    ks_byte_s   = 8'd0;
`endif
    case (state_s)
      IDLE: rdy_s = 1'b1;
      WRITE_LEN: begin
        pt_addr_s   = 8'd0;
        pt_wrdata_s = len_s;
        pt_wren_s   = 1'b1;
      end
      READ_I: s_addr_s = i_s;
      READ_J: s_addr_s = j_s;
      // When i == j, WRITE_I and WRITE_J store the same byte twice. This is harmless.
      WRITE_I: begin
        s_addr_s   = i_s;
        s_wrdata_s = sj_s;
        s_wren_s   = 1'b1;
      end
      WRITE_J: begin
        s_addr_s   = j_s;
        s_wrdata_s = si_s;
        s_wren_s   = 1'b1;
      end
      READ_PAD: begin
        s_addr_s  = si_s + sj_s;
        ct_addr_s = k_s;
      end
      WRITE_PT: begin
        pt_addr_s   = k_s;
        pt_wrdata_s = pad_s ^ ct_byte_s;
        pt_wren_s   = 1'b1;
`ifdef PRGA_KS_TAP_EN
        ks_valid_s  = 1'b1;
        ks_byte_s   = pad_s;
`endif
      end
      default: rdy_s = 1'b0;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      i_r       <= 8'd0;
      j_r       <= 8'd0;
      k_r       <= 8'd0;
      len_r     <= 8'd0;
      si_r      <= 8'd0;
      sj_r      <= 8'd0;
      pad_r     <= 8'd0;
      ct_byte_r <= 8'd0;
      rdy       <= 1'b1;
      s_addr    <= 8'd0;
      s_wrdata  <= 8'd0;
      s_wren    <= 1'b0;
      ct_addr   <= 8'd0;
      pt_addr   <= 8'd0;
      pt_wrdata <= 8'd0;
      pt_wren   <= 1'b0;
`ifdef PRGA_KS_TAP_EN
      ks_valid  <= 1'b0;
      ks_byte   <= 8'd0;
`endif
    end else begin
      state_r   <= state_s;
      i_r       <= i_s;
      j_r       <= j_s;
      k_r       <= k_s;
      len_r     <= len_s;
      si_r      <= si_s;
      sj_r      <= sj_s;
      pad_r     <= pad_s;
      ct_byte_r <= ct_byte_s;
      rdy       <= rdy_s;
      s_addr    <= s_addr_s;
      s_wrdata  <= s_wrdata_s;
      s_wren    <= s_wren_s;
      ct_addr   <= ct_addr_s;
      pt_addr   <= pt_addr_s;
      pt_wrdata <= pt_wrdata_s;
      pt_wren   <= pt_wren_s;
`ifdef PRGA_KS_TAP_EN
      ks_valid  <= ks_valid_s;
      ks_byte   <= ks_byte_s;
`endif
    end
  end

endmodule

// File: tb/tb_prga.sv
// tb_prga - self-checking bench for prga.
// Models the S, CT and PT memories (synchronous read, 1-cycle latency).
// A reference RC4 model pushes every expected PT write (and keystream byte)
// into a queue. The queue is popped when the DUT asserts pt_wren.
module tb_prga;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       rdy;
  logic [7:0] s_addr, s_rddata, s_wrdata;
  logic       s_wren;
  logic [7:0] ct_addr, ct_rddata;
  logic [7:0] pt_addr, pt_wrdata;
  logic       pt_wren;
`ifdef PRGA_KS_TAP_EN
  logic       ks_valid;
  logic [7:0] ks_byte;
`endif

  prga dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .rdy       (rdy),
    .s_addr    (s_addr),
    .s_rddata  (s_rddata),
    .s_wrdata  (s_wrdata),
    .s_wren    (s_wren),
    .ct_addr   (ct_addr),
    .ct_rddata (ct_rddata),
    .pt_addr   (pt_addr),
    .pt_wrdata (pt_wrdata),
    .pt_wren   (pt_wren)
`ifdef PRGA_KS_TAP_EN
    ,
    .ks_valid  (ks_valid),
    .ks_byte   (ks_byte)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0] s_mem  [256];
  logic [7:0] s_load [256];
  logic [7:0] s_exp  [256];
  logic [7:0] ct_mem [256];
  logic [7:0] pt_mem [256];
  logic       load_s = 1'b0;

  // Memory models: 1-cycle synchronous read; bulk S load while DUT is idle.
  always @(posedge clk) begin
    s_rddata  <= s_mem[s_addr];
    ct_rddata <= ct_mem[ct_addr];
    if (load_s) s_mem <= s_load;
    else if (s_wren) s_mem[s_addr] <= s_wrdata;
    if (pt_wren) pt_mem[pt_addr] <= pt_wrdata;
  end

  typedef struct packed {
    logic       kv;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] pad;
  } pt_exp_t;
  pt_exp_t sb[$];

  typedef struct {
    int len;
    int s_mode;      // 0 identity, 1 ksa key 00033C, 2 reversed
    int ct_mode;     // 0 zeros, 1 pattern, 2 random
    int exp_cycles;  // accept edge to rdy high
  } vec_t;
  vec_t vecs[5];

  int n_cmp = 0;
  int n_fail = 0;
  int s_writes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_sbox(input int mode);
    logic [7:0] key [3];
    logic [7:0] j, t;
    key[0] = 8'h00; key[1] = 8'h03; key[2] = 8'h3C;
    for (int n = 0; n < 256; n++) s_load[n] = (mode == 2) ? 8'(255 - n) : 8'(n);
    if (mode == 1) begin
      j = 8'd0;
      for (int n = 0; n < 256; n++) begin
        j = j + s_load[n] + key[n % 3];
        t = s_load[n]; s_load[n] = s_load[j]; s_load[j] = t;
      end
    end
    load_s = 1'b1;
    @(posedge clk);
    #1 load_s = 1'b0;
  endtask

  task automatic load_ct(input int len, input int mode);
    ct_mem[0] = 8'(len);
    for (int n = 1; n < 256; n++) begin
      case (mode)
        0:       ct_mem[n] = 8'h00;
        1:       ct_mem[n] = 8'(n * 7 + 8'h41);
        default: ct_mem[n] = 8'($urandom_range(255, 0));
      endcase
    end
  endtask

  // Reference RC4 PRGA: queues the expected PT writes and predicts final S.
  task automatic build_expected(input int len);
    logic [7:0] i, j, t, idx, pad;
    s_exp = s_load;
    i = 8'd0; j = 8'd0;
    sb.push_back('{1'b0, 8'h00, 8'(len), 8'h00});
    for (int k = 1; k <= len; k++) begin
      i = i + 8'd1;
      j = j + s_exp[i];
      t = s_exp[i]; s_exp[i] = s_exp[j]; s_exp[j] = t;
      idx = s_exp[i] + s_exp[j];
      pad = s_exp[idx];
      sb.push_back('{1'b1, 8'(k), pad ^ ct_mem[k], pad});
    end
  endtask

  task automatic monitor_cycle();
    pt_exp_t e;
    if (s_wren) s_writes++;
    if (pt_wren) begin
      if (sb.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL pt_extra_write: got write addr %0h data %0h expected none", pt_addr, pt_wrdata);
      end else begin
        e = sb.pop_front();
        check("pt_addr", pt_addr, e.addr);
        check("pt_data", pt_wrdata, e.data);
`ifdef PRGA_KS_TAP_EN
        check("ks_valid", ks_valid, e.kv);
        check("ks_byte", ks_byte, e.kv ? e.pad : 8'h00);
`endif
      end
    end else begin
`ifdef PRGA_KS_TAP_EN
      check("ks_idle", {ks_valid, ks_byte}, 9'd0);
`endif
    end
  endtask

  // Starts a run and monitors it until rdy returns high. The wait is bounded.
  task automatic run(input logic hold_en, input int exp_cycles);
    int  cycles;
    logic done;
    en = 1'b1;
    @(posedge clk);
    #1 en = hold_en;
    check("rdy_fall", rdy, 1'b0);
    cycles = 0; done = 1'b0;
    while (!done && cycles < 3000) begin
      @(negedge clk);
      monitor_cycle();
      @(posedge clk);
      cycles++;
      #1 if (rdy) done = 1'b1;
    end
    if (!done) $display("FAIL run_timeout: got no rdy after %0d cycles expected %0d", cycles, exp_cycles);
    check("latency", cycles, exp_cycles);
    check("sb_drained", sb.size(), 0);
  endtask

  int bad;

  initial begin
    vecs[0] = '{0,   0, 1, 3};
    vecs[1] = '{255, 1, 0, 2298};
    vecs[2] = '{5,   2, 2, 48};
    vecs[3] = '{17,  1, 1, 156};
    vecs[4] = '{1,   2, 1, 12};

    // Asynchronous reset asserted mid-cycle: outputs respond without an edge.
    #2 rst_n = 1'b0;
    #1;
    check("rst_rdy", rdy, 1'b1);
    check("rst_wren", {s_wren, pt_wren}, 2'b00);
    check("rst_addr", {s_addr, ct_addr, pt_addr}, 24'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Reset during WRITE_J of byte 2 (identity S, L=3).
    load_sbox(0);
    load_ct(3, 0);
    ct_mem[1] = 8'h41; ct_mem[2] = 8'h42; ct_mem[3] = 8'h43;
    en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    repeat (17) @(posedge clk);
    @(negedge clk);
    check("wj_wren", s_wren, 1'b1);
    check("wj_addr", s_addr, 8'h03);
    check("wj_data", s_wrdata, 8'h02);
    rst_n = 1'b0;
    #1;
    check("midrun_rdy", rdy, 1'b1);
    check("midrun_wren", {s_wren, pt_wren}, 2'b00);
    check("midrun_addr", {s_addr, ct_addr, pt_addr, s_wrdata}, 32'd0);
    @(posedge clk);
    #1 check("midrun_s3_kept", s_mem[3], 8'h03);
    @(negedge clk) rst_n = 1'b1;

    // Fresh identity run after reset: must restart with i=j=0.
    load_sbox(0);
    build_expected(3);
    run(1'b0, 30);
    check("pt0", pt_mem[0], 8'h03);
    check("pt1", pt_mem[1], 8'h43);
    check("pt2", pt_mem[2], 8'h47);
    check("pt3", pt_mem[3], 8'h44);
    check("s2", s_mem[2], 8'h03);
    check("s3", s_mem[3], 8'h05);
    check("s5", s_mem[5], 8'h02);
    bad = 0;
    for (int n = 0; n < 256; n++)
      if (n != 2 && n != 3 && n != 5 && s_mem[n] != 8'(n)) bad++;
    check("s_others", bad, 0);

    // Table-driven runs.
    for (int v = 0; v < 5; v++) begin
      load_sbox(vecs[v].s_mode);
      load_ct(vecs[v].len, vecs[v].ct_mode);
      build_expected(vecs[v].len);
      s_writes = 0;
      run(1'b0, vecs[v].exp_cycles);
      check("s_write_count", s_writes, 2 * vecs[v].len);
      bad = 0;
      for (int n = 0; n < 256; n++) if (s_mem[n] !== s_exp[n]) bad++;
      check("s_final", bad, 0);
    end

    // en held high through completion starts a second run back to back.
    load_sbox(0);
    load_ct(0, 0);
    build_expected(0);
    run(1'b1, 3);
    build_expected(0);
    run(1'b0, 3);
    @(posedge clk);
    #1 check("idle_after", rdy, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
